// File: rtl/pio_blink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_blink_pkg
//  Description : Shared types and constants for the PIO blink master.
//                Holds the FSM state encoding, the PIO register offsets and
//                the Avalon-MM data width.
//  Revision    : 1.0  initial release
// ============================================================================
package pio_blink_pkg;

    localparam int AVM_DATA_W = 32;

    // PIO slave register map (word offsets on the Avalon address bus)
    localparam logic [2:0] PIO_DATA   = 3'd0;
    localparam logic [2:0] PIO_OUTSET = 3'd4;
    localparam logic [2:0] PIO_OUTCLR = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pio_blink_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pio_blink_timer
//  Description : Period counter for the PIO blink master. Counts while
//                i_inc is high, returns to zero on i_clr, and flags the last
//                count of the period on o_tc.
//  Ports       : clk      - system clock
//                reset_n  - asynchronous active-low reset
//                i_clr    - synchronous clear (dominates i_inc)
//                i_inc    - advance the counter by one
//                o_tc     - counter equals PERIOD_CYCLES-1
//  Revision    : 1.0  initial release
// ============================================================================
module pio_blink_timer #(
    parameter int unsigned PERIOD_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam int unsigned          CNT_W    = $clog2(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0]     TC_VALUE = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_tc = (count_q == TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/pio_blink_master.sv
`default_nettype none
// ============================================================================
//  Module      : pio_blink_master
//  Description : Avalon-MM master that toggles a single-bit output PIO by
//                alternately writing its OUTSET (4) and OUTCLR (5) registers
//                every PERIOD_CYCLES clocks.
//                Optional build macro PIO_BLINK_VERIFY_READBACK_EN adds a
//                read of the PIO data register after each write; a mismatch
//                against the expected level sets the sticky err flag.
//  Ports       : clk, reset_n          - clock, async active-low reset
//                enable                - run/stop toggling (level)
//                address .. writedata  - Avalon-MM master outputs
//                readdata, waitrequest - Avalon-MM master inputs
//                busy                  - FSM not idle
//                toggle_count          - completed toggle writes (wraps)
//                err                   - sticky readback mismatch
//  Revision    : 1.0  initial release
// ============================================================================
module pio_blink_master
    import pio_blink_pkg::*;
#(
    parameter int unsigned            PERIOD_CYCLES = 50000000,
    parameter logic [AVM_DATA_W-1:0]  BIT_MASK      = 32'h1,
    parameter logic                   INIT_LEVEL    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    output logic [2:0]             address,
    output logic                   chipselect,
    output logic                   write_n,
    output logic                   read_n,
    output logic [AVM_DATA_W-1:0]  writedata,
    input  logic [AVM_DATA_W-1:0]  readdata,
    input  logic                   waitrequest,
    output logic                   busy,
    output logic [15:0]            toggle_count,
    output logic                   err
);

    state_e                  state_q,        state_d;
    logic                    shadow_q,       shadow_d;
    logic [15:0]             toggle_count_q, toggle_count_d;
    logic                    err_q,          err_d;
    logic                    busy_q,         busy_d;
    logic [2:0]              address_q,      address_d;
    logic                    chipselect_q,   chipselect_d;
    logic                    write_n_q,      write_n_d;
    logic                    read_n_q,       read_n_d;
    logic [AVM_DATA_W-1:0]   writedata_q,    writedata_d;

    logic w_tc;
    logic w_timer_clr;
    logic w_timer_inc;
    logic w_unused;

    // The period counter only runs in COUNT; every other state holds it at
    // zero so each COUNT entry starts a fresh full period.
    assign w_timer_inc = (state_q == COUNT);
    assign w_timer_clr = (state_q != COUNT) || w_tc;

    pio_blink_timer #(
        .PERIOD_CYCLES (PERIOD_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_timer_clr),
        .i_inc   (w_timer_inc),
        .o_tc    (w_tc)
    );

    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        toggle_count_d = toggle_count_q;
        err_d          = err_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (w_tc) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!waitrequest) begin
                    shadow_d       = ~shadow_q;
                    toggle_count_d = toggle_count_q + 16'd1;
`ifdef PIO_BLINK_VERIFY_READBACK_EN
                    state_d        = READ;
`else
                    state_d        = COUNT;
`endif
                end
            end
`ifdef PIO_BLINK_VERIFY_READBACK_EN
            READ: begin
                // shadow_q already holds the level the write should produce
                if (!waitrequest) begin
                    if (readdata[0] != shadow_q) begin
                        err_d = 1'b1;
                    end
                    state_d = COUNT;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus outputs are decoded from the next state so the registered
        // outputs line up with the state they belong to; while waitrequest
        // stalls, state and shadow are unchanged so the bus holds steady.
        address_d    = PIO_DATA;
        chipselect_d = 1'b0;
        write_n_d    = 1'b1;
        read_n_d     = 1'b1;
        writedata_d  = '0;
        case (state_d)
            WRITE: begin
                chipselect_d = 1'b1;
                write_n_d    = 1'b0;
                writedata_d  = BIT_MASK;
                address_d    = shadow_d ? PIO_OUTCLR : PIO_OUTSET;
            end
            READ: begin
                chipselect_d = 1'b1;
                read_n_d     = 1'b0;
                address_d    = PIO_DATA;
            end
            default: begin
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            shadow_q       <= INIT_LEVEL;
            toggle_count_q <= 16'd0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            address_q      <= 3'd0;
            chipselect_q   <= 1'b0;
            write_n_q      <= 1'b1;
            read_n_q       <= 1'b1;
            writedata_q    <= '0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            toggle_count_q <= toggle_count_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
            address_q      <= address_d;
            chipselect_q   <= chipselect_d;
            write_n_q      <= write_n_d;
            read_n_q       <= read_n_d;
            writedata_q    <= writedata_d;
        end
    end

    assign address      = address_q;
    assign chipselect   = chipselect_q;
    assign write_n      = write_n_q;
    assign writedata    = writedata_q;
    assign busy         = busy_q;
    assign toggle_count = toggle_count_q;

`ifdef PIO_BLINK_VERIFY_READBACK_EN
    assign read_n   = read_n_q;
    assign err      = err_q;
    // Only bit 0 of the PIO data register carries the output level
    assign w_unused = ^readdata[AVM_DATA_W-1:1];
`else
    assign read_n   = 1'b1;
    assign err      = 1'b0;
    assign w_unused = ^{readdata, read_n_q, err_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pio_blink_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pio_blink_master
//  Description : Self-checking bench for pio_blink_master with a PIO slave
//                model and a period/phase based reference model.
//                Honours PIO_BLINK_VERIFY_READBACK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pio_blink_master;

    localparam int P = 4;
`ifdef PIO_BLINK_VERIFY_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b0;
    logic        enable      = 1'b0;
    logic        waitrequest = 1'b0;
    logic        force_rd    = 1'b0;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busy;
    logic [15:0] toggle_count;
    logic        err;
    logic        pio_out;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    pio_blink_master #(
        .PERIOD_CYCLES (P),
        .BIT_MASK      (32'h1),
        .INIT_LEVEL    (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .read_n       (read_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .waitrequest  (waitrequest),
        .busy         (busy),
        .toggle_count (toggle_count),
        .err          (err)
    );

    // ---------------- PIO slave model ----------------
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_out <= 1'b1;
        end else if (chipselect && !write_n && !waitrequest) begin
            if (address == 3'd4) pio_out <= pio_out | writedata[0];
            else if (address == 3'd5) pio_out <= pio_out & ~writedata[0];
        end
    end
    assign readdata = {31'd0, force_rd ? 1'b1 : pio_out};

    // ---------------- Reference model ----------------
    // m_pos is the position inside one toggle period: 0..P-1 counting,
    // P = write transaction, P+1 = readback transaction.
    bit          m_run;
    int          m_pos;
    bit          m_shadow;
    logic [15:0] m_count;
    bit          m_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 0; m_pos = 0; m_shadow = 1; m_count = 16'd0; m_err = 0;
        end else if (!m_run) begin
            if (enable) begin m_run = 1; m_pos = 0; end
        end else if (m_pos < P) begin
            if (!enable) m_run = 0;
            else m_pos = m_pos + 1;
        end else if (m_pos == P) begin
            if (!waitrequest) begin
                m_shadow = !m_shadow;
                m_count  = m_count + 16'd1;
                m_pos    = (RB == 1) ? P + 1 : 0;
            end
        end else begin
            if (!waitrequest) begin
                if (readdata[0] != m_shadow) m_err = 1;
                m_pos = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (checking) begin
            logic        in_w, in_r;
            logic [63:0] e, a;
            in_w = m_run && (m_pos == P);
            in_r = m_run && (m_pos == P + 1);
            e = {7'd0, in_w ? (m_shadow ? 3'd5 : 3'd4) : 3'd0, in_w || in_r, !in_w, !in_r,
                 in_w ? 32'd1 : 32'd0, m_run, m_count, m_err, m_shadow};
            a = {7'd0, address, chipselect, write_n, read_n, writedata, busy,
                 toggle_count, err, pio_out};
            chk("cycle_model", a, e);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    logic [15:0] wrap_exp [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    int guard;

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        tick(2);
        checking = 1'b1;
        chk("reset_state", {address, chipselect, write_n, read_n, writedata, busy, toggle_count, err},
            {3'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 16'd0, 1'b0});
        reset_n = 1'b1;

        // ---- basic toggling ----
        tick(1);
        chk("count_busy", busy, 1);
        tick(3);
        chk("no_bus_in_count", chipselect, 0);
        tick(1);
        chk("first_write", {address, chipselect, write_n, writedata}, {3'd5, 1'b1, 1'b0, 32'd1});
        tick(1);
`ifdef PIO_BLINK_VERIFY_READBACK_EN
        chk("readback_cycle", {address, chipselect, read_n, write_n}, {3'd0, 1'b1, 1'b0, 1'b1});
        tick(1);
`endif
        chk("after_first", {pio_out, toggle_count}, {1'b0, 16'd1});
        tick(4);
        chk("second_write", {address, chipselect, write_n}, {3'd4, 1'b1, 1'b0});
        tick(1 + RB);
        chk("two_periods", {pio_out, toggle_count}, {1'b1, 16'd2});

        // ---- waitrequest stall for 3 cycles ----
        tick(4);
        waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) waitrequest = 1'b0;
            chk($sformatf("stall_hold_%0d", i), {address, chipselect, write_n, writedata},
                {3'd5, 1'b1, 1'b0, 32'd1});
            tick(1);
        end
        chk("stall_one_toggle", toggle_count, 16'd3);
`ifdef PIO_BLINK_VERIFY_READBACK_EN
        tick(1);

        // ---- readback mismatch ----
        chk("err_clear_before", err, 0);
        force_rd = 1'b1;
        tick(6);            // set write, readback matches
        tick(5);            // clear write, now in READ with forced 1
        chk("err_not_yet", err, 0);
        tick(1);
        chk("err_set", err, 1);
        force_rd = 1'b0;
        tick(12);
        chk("err_sticky", err, 1);
`endif

        // ---- enable dropped during a stalled write ----
        tick(4);
        enable = 1'b0;
        waitrequest = 1'b1;
        tick(1);
        chk("drop_hold", {chipselect, write_n, address}, {1'b1, 1'b0, 3'd4});
        tick(1);
        waitrequest = 1'b0;
        tick(1 + RB);
        chk("drop_count", {busy, chipselect}, {1'b1, 1'b0});
        tick(1);
        chk("drop_idle", {busy, chipselect}, {1'b0, 1'b0});
        enable = 1'b1;
        tick(4);
        chk("reenable_quiet", chipselect, 0);
        tick(1);
        chk("reenable_write", {chipselect, address}, {1'b1, 3'd5});

        // ---- async reset mid-transaction ----
`ifdef PIO_BLINK_VERIFY_READBACK_EN
        tick(1);
`endif
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset", {address, chipselect, write_n, read_n, writedata, busy, toggle_count, err},
            {3'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 16'd0, 1'b0});
        tick(1);
        reset_n = 1'b1;
        tick(5);
        chk("post_reset_write", {chipselect, address}, {1'b1, 3'd5});

        // ---- toggle_count wrap (preloaded near the top) ----
        enable = 1'b0;
        guard = 0;
        while (busy && guard < 50) begin
            tick(1);
            guard++;
        end
        chk("idle_before_preload", busy, 0);
        force dut.toggle_count_q = 16'hFFFD;
        m_count = 16'hFFFD;
        tick(1);
        release dut.toggle_count_q;
        chk("preload", toggle_count, 16'hFFFD);
        enable = 1'b1;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            tick(4 + 1 + RB);
            chk($sformatf("wrap_%0d", k), toggle_count, {48'd0, wrap_exp[k]});
        end

        // ---- randomized run against the model ----
        for (int i = 0; i < 3000; i++) begin
            enable      = ($urandom_range(0, 15) != 0);
            waitrequest = ($urandom_range(0, 3) == 0);
            force_rd    = (RB == 1) && ($urandom_range(0, 31) == 0);
            tick(1);
        end

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
